// File: rtl/gather_pkg.sv
// Shared types and constants for the gather merge stage and its skid buffer.
package gather_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int ELEM_W     = 16;

    typedef logic [ELEM_W-1:0] elem_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry registered ready/valid FIFO; head entry drives the output directly.
module skid_buffer
    import gather_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    output logic          full,
    output logic          out_valid,
    output logic [PW-1:0] out_data,
    input  logic          out_ready
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic             push, pop;

    assign full      = (cnt_q == CNT_W'(SKID_DEPTH));
    assign out_valid = (cnt_q != '0);
    assign out_data  = head_q;
    assign push      = in_valid && !full;
    assign pop       = out_ready && out_valid;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (pop) begin
            if (cnt_q == CNT_W'(SKID_DEPTH)) begin
                head_d = tail_q;
            end else if (push) begin
                head_d = in_data;
            end
        end else if (push) begin
            if (cnt_q == '0) begin
                head_d = in_data;
            end else begin
                tail_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/gather.sv
// Joins large/small column streams and rebuilds dense rows using a per-tensor column map.
// Optional zero-fill violation check enabled by defining GATHER_ZERO_CHECK_EN.
module gather
    import gather_pkg::*;
#(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int IN_DEPTH       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] data_in_large [IN_SIZE*IN_PARALLELISM],
    input  logic                data_in_large_valid,
    output logic                data_in_large_ready,
    input  logic [IN_WIDTH-1:0] data_in_small [IN_SIZE*IN_PARALLELISM],
    input  logic                data_in_small_valid,
    output logic                data_in_small_ready,
    input  logic [IN_SIZE-1:0]  ind_table,
    output logic [IN_WIDTH-1:0] data_out [IN_SIZE*IN_PARALLELISM],
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                last_out,
    output logic                err
);

    localparam int N  = IN_SIZE * IN_PARALLELISM;
    localparam int CW = $clog2(IN_DEPTH + 1);
    localparam int PW = IN_WIDTH * N + 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [IN_SIZE-1:0] tbl_q, tbl_d;
    logic [IN_SIZE-1:0] sel_tbl;
    logic               last_tag;
    logic               accept;
    logic               full;
    logic [PW-1:0]      payload_in, payload_out;

    // Readys depend only on the other side's valid and current occupancy.
    assign data_in_large_ready = !rst && data_in_small_valid && !full;
    assign data_in_small_ready = !rst && data_in_large_valid && !full;
    assign accept  = !rst && data_in_large_valid && data_in_small_valid && !full;
    assign sel_tbl = (state_q == IDLE) ? ind_table : tbl_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        tbl_d      = tbl_q;
        last_tag   = 1'b0;
        if (accept) begin
            if (state_q == IDLE) begin
                tbl_d = ind_table;
                if (IN_DEPTH == 1) begin
                    last_tag   = 1'b1;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = CW'(1);
                    state_d    = BUSY;
                end
            end else if (beat_cnt_q == CW'(IN_DEPTH - 1)) begin
                last_tag   = 1'b1;
                beat_cnt_d = '0;
                state_d    = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            tbl_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            tbl_q      <= tbl_d;
        end
    end

    always_comb begin
        payload_in = '0;
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            for (int c = 0; c < IN_SIZE; c++) begin
                payload_in[(r*IN_SIZE+c)*IN_WIDTH +: IN_WIDTH] =
                    sel_tbl[c] ? data_in_large[r*IN_SIZE+c] : data_in_small[r*IN_SIZE+c];
            end
        end
        payload_in[PW-1] = last_tag;
    end

    skid_buffer #(
        .PW(PW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .in_data  (payload_in),
        .full     (full),
        .out_valid(data_out_valid),
        .out_data (payload_out),
        .out_ready(data_out_ready)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_out[i] = payload_out[i*IN_WIDTH +: IN_WIDTH];
        end
        last_out = payload_out[PW-1];
    end

`ifdef GATHER_ZERO_CHECK_EN
    logic err_q, err_d;
    logic violation;

    // The path not chosen for a column must carry zeros on every accepted beat.
    always_comb begin
        violation = 1'b0;
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            for (int c = 0; c < IN_SIZE; c++) begin
                if (sel_tbl[c] ? (data_in_small[r*IN_SIZE+c] != '0)
                               : (data_in_large[r*IN_SIZE+c] != '0)) begin
                    violation = 1'b1;
                end
            end
        end
        err_d = err_q || (accept && violation);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gather.sv
// Directed and randomized bench for gather, scored against a queue-based reference model.
module tb_gather;
    import gather_pkg::*;

    localparam int DEPTH = 2;
`ifdef GATHER_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    typedef struct {
        logic [63:0] d;
        bit          last;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    elem_t      lg [4];
    elem_t      sm [4];
    elem_t      dout [4];
    logic       lv = 1'b0, sv = 1'b0;
    logic       lr, sr;
    logic [3:0] ind = 4'b0;
    logic       dout_valid, dout_ready = 1'b1, last_out, err;
    logic [63:0] dout_p, lg_p, sm_p;

    ent_t        q[$];
    int          pos = 0;
    logic [3:0]  ttbl = 4'b0;
    bit          merr = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign dout_p = {dout[3], dout[2], dout[1], dout[0]};
    assign lg_p   = {lg[3], lg[2], lg[1], lg[0]};
    assign sm_p   = {sm[3], sm[2], sm[1], sm[0]};

    gather #(
        .IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .IN_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in_large(lg), .data_in_large_valid(lv), .data_in_large_ready(lr),
        .data_in_small(sm), .data_in_small_valid(sv), .data_in_small_ready(sr),
        .ind_table(ind),
        .data_out(dout), .data_out_valid(dout_valid), .data_out_ready(dout_ready),
        .last_out(last_out), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] eff_tbl();
        return (pos == 0) ? ind : ttbl;
    endfunction

    task automatic set_beat(input logic [63:0] l, input logic [63:0] s);
        for (int c = 0; c < 4; c++) begin
            lg[c] = l[c*16 +: 16];
            sm[c] = s[c*16 +: 16];
        end
    endtask

    // Random data that respects zero-fill for the table the next accepted beat will use.
    task automatic rand_beat();
        logic [3:0]  t;
        logic [63:0] l, s;
        t = eff_tbl();
        l = '0;
        s = '0;
        for (int c = 0; c < 4; c++) begin
            if (t[c]) l[c*16 +: 16] = 16'($urandom);
            else      s[c*16 +: 16] = 16'($urandom);
        end
        set_beat(l, s);
    endtask

    // One clock: compare outputs with the model, advance the model across the edge.
    task automatic cycle();
        bit          acc, pop, full, viol;
        logic [3:0]  t;
        logic [63:0] m;
        ent_t        e;
        #1;
        full = (q.size() == 2);
        chk("valid", dout_valid, q.size() > 0);
        chk("large_ready", lr, !rst && sv && !full);
        chk("small_ready", sr, !rst && lv && !full);
        chk("err", err, merr);
        if (q.size() > 0) begin
            chk("data", dout_p, q[0].d);
            chk("last", last_out, q[0].last);
        end
        acc  = !rst && lv && sv && !full;
        pop  = dout_ready && q.size() > 0;
        t    = eff_tbl();
        m    = '0;
        viol = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m[c*16 +: 16] = t[c] ? lg_p[c*16 +: 16] : sm_p[c*16 +: 16];
            if (t[c] ? (sm_p[c*16 +: 16] != 0) : (lg_p[c*16 +: 16] != 0)) viol = 1'b1;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            pos  = 0;
            ttbl = 4'b0;
            merr = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (pos == 0) ttbl = ind;
                e.d    = m;
                e.last = (pos == DEPTH - 1);
                q.push_back(e);
                pos = e.last ? 0 : pos + 1;
                if (ZC && viol) merr = 1'b1;
            end
        end
    endtask

    initial begin
        set_beat('0, '0);
        @(posedge clk);
        cycle();
        cycle();
        chk("reset_valid", dout_valid, 0);
        chk("reset_data", dout_p, 0);
        chk("reset_last", last_out, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;

        // Basic merge, then table hold across the tensor, then a fresh tensor.
        ind = 4'b1010;
        set_beat(64'h3C00_0000_4000_0000, 64'h0000_1111_0000_2222);
        lv = 1; sv = 1;
        cycle();
        lv = 0; sv = 0;
        chk("basic_data", dout_p, 64'h3C00_1111_4000_2222);
        chk("basic_last", last_out, 0);
        ind = 4'b0101;
        set_beat(64'h5555_0000_6666_0000, 64'h0000_7777_0000_8888);
        lv = 1; sv = 1;
        cycle();
        chk("hold_data", dout_p, 64'h5555_7777_6666_8888);
        chk("hold_last", last_out, 1);
        set_beat(64'h0000_AAAA_0000_BBBB, 64'hCCCC_0000_DDDD_0000);
        cycle();
        lv = 0; sv = 0;
        chk("new_tbl_data", dout_p, 64'hCCCC_AAAA_DDDD_BBBB);
        chk("new_tbl_last", last_out, 0);
        lv = 1; sv = 1;
        cycle();
        lv = 0; sv = 0;
        chk("tensor2_last", last_out, 1);
        cycle();

        // Join stall: lone large valid must never be consumed.
        ind = 4'b1111;
        set_beat(64'h1234_5678_9ABC_DEF0, '0);
        lv = 1; sv = 0;
        cycle();
        cycle();
        chk("stall_no_out", dout_valid, 0);
        sv = 1;
        cycle();
        lv = 0; sv = 0;
        chk("stall_one_out", dout_valid, 1);
        cycle();
        chk("stall_drained", dout_valid, 0);

        // Backpressure: only two beats fit, then drain in order.
        dout_ready = 0;
        lv = 1; sv = 1;
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            cycle();
        end
        chk("bp_large_ready", lr, 0);
        chk("bp_small_ready", sr, 0);
        chk("bp_depth", q.size(), 2);
        lv = 0; sv = 0;
        dout_ready = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_empty", dout_valid, 0);

        // Mid-tensor reset discards the partial tensor.
        rst = 1; cycle(); rst = 0;
        ind = 4'b1100;
        rand_beat();
        lv = 1; sv = 1;
        cycle();
        lv = 0; sv = 0;
        rst = 1;
        cycle();
        rst = 0;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_data", dout_p, 0);
        ind = 4'b0011;
        set_beat(64'h0000_0000_2468_1357, 64'hFEDC_BA98_0000_0000);
        lv = 1; sv = 1;
        cycle();
        lv = 0; sv = 0;
        chk("mid_rst_fresh", dout_p, 64'hFEDC_BA98_2468_1357);
        chk("mid_rst_not_last", last_out, 0);
        rst = 1; cycle(); rst = 0;

        // Zero-fill violation: nonzero on the small path of a large-selected column.
        ind = 4'b1000;
        set_beat(64'h3C00_0000_0000_0000, 64'h0001_0000_0000_0000);
        lv = 1; sv = 1;
        cycle();
        lv = 0; sv = 0;
        chk("zc_rise", err, ZC);
        cycle();
        cycle();
        chk("zc_sticky", err, ZC);
        rst = 1; cycle(); rst = 0;
        chk("zc_clear", err, 0);

        // Randomized traffic with backpressure, table churn and occasional reset.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            lv         = ($urandom_range(0, 3) != 0);
            sv         = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 3) != 0);
            ind        = 4'($urandom);
            rand_beat();
            cycle();
        end
        rst = 0; lv = 0; sv = 0; dout_ready = 1;
        for (int i = 0; i < 4; i++) cycle();
        chk("final_empty", dout_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
